// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one DMA/RAM port between NREQ requesters, one transaction at a time.
// Optional DMA completion timeout enabled by defining RAM_ARB_TIMEOUT_EN.
module ram_port_arbiter #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [DW-1:0]        rdata,
    output logic                 err,
    output logic [AW-1:0]        ram_address,
    output logic [DW-1:0]        ram_data_in,
    output logic                 ram_read,
    output logic                 ram_write,
    input  logic [DW-1:0]        ram_data_out,
    input  logic                 ram_done_read,
    input  logic                 ram_done_write
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Elaboration-time range checks on the parameters.
    if (NREQ < 2 || NREQ > 8) begin : gBadNreq
        $error("ram_port_arbiter: NREQ must be 2..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : gBadTimeout
        $error("ram_port_arbiter: TIMEOUT must be 1..255");
    end

    logic [1:0]      state, stateNext;
    logic [IW-1:0]   idx, idxNext;
    logic [IW-1:0]   ptr, ptrNext;
    logic            weL, weNext;
    logic [NREQ-1:0] grantNext, doneNext;
    logic [DW-1:0]   rdataNext;
    logic            errNext;
    logic [AW-1:0]   addrNext;
    logic [DW-1:0]   dataNext;
    logic            readNext, writeNext;
    logic            anyReq;
    logic            matchDone;
    logic [IW-1:0]   idxInc;
    int              pickIdx;
`ifdef RAM_ARB_TIMEOUT_EN
    logic [CW-1:0]   cnt, cntNext;
`endif

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        anyReq  = 1'b0;
        pickIdx = 0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!anyReq && req[(int'(ptr) + i) % int'(NREQ)]) begin
                anyReq  = 1'b1;
                pickIdx = (int'(ptr) + i) % int'(NREQ);
            end
        end
    end

    assign idxInc    = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
    assign matchDone = weL ? ram_done_write : ram_done_read;

    always_comb begin
        stateNext = state;
        idxNext   = idx;
        ptrNext   = ptr;
        weNext    = weL;
        grantNext = grant;
        doneNext  = '0;
        errNext   = 1'b0;
        rdataNext = rdata;
        addrNext  = ram_address;
        dataNext  = ram_data_in;
        readNext  = ram_read;
        writeNext = ram_write;
`ifdef RAM_ARB_TIMEOUT_EN
        cntNext   = cnt;
`endif
        case (state)
            IDLE: begin
                grantNext = '0;
                addrNext  = '0;
                dataNext  = '0;
                readNext  = 1'b0;
                writeNext = 1'b0;
                if (anyReq) begin
                    stateNext = BUSY;
                    idxNext   = IW'(pickIdx);
                    weNext    = we[pickIdx];
                    addrNext  = addr[pickIdx*AW +: AW];
                    dataNext  = wdata[pickIdx*DW +: DW];
                    grantNext = NREQ'(1) << pickIdx;
                    readNext  = ~we[pickIdx];
                    writeNext = we[pickIdx];
`ifdef RAM_ARB_TIMEOUT_EN
                    cntNext   = '0;
`endif
                end
            end
            BUSY: begin
                if (matchDone) begin
                    stateNext = DONE;
                    doneNext  = grant;
                    readNext  = 1'b0;
                    writeNext = 1'b0;
                    if (!weL) begin
                        rdataNext = ram_data_out;
                    end
                end
`ifdef RAM_ARB_TIMEOUT_EN
                // Abandon the transaction: report it as done with err, skip the DONE state.
                else if (cnt == CW'(TIMEOUT - 1)) begin
                    stateNext = IDLE;
                    doneNext  = grant;
                    errNext   = 1'b1;
                    readNext  = 1'b0;
                    writeNext = 1'b0;
                    addrNext  = '0;
                    dataNext  = '0;
                    ptrNext   = idxInc;
                end else begin
                    cntNext = cnt + 1'b1;
                end
`endif
            end
            DONE: begin
                stateNext = IDLE;
                grantNext = '0;
                addrNext  = '0;
                dataNext  = '0;
                ptrNext   = idxInc;
            end
            default: begin
                stateNext = IDLE;
                grantNext = '0;
                readNext  = 1'b0;
                writeNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            idx         <= '0;
            ptr         <= '0;
            weL         <= 1'b0;
            grant       <= '0;
            done        <= '0;
            rdata       <= '0;
            err         <= 1'b0;
            ram_address <= '0;
            ram_data_in <= '0;
            ram_read    <= 1'b0;
            ram_write   <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
            cnt         <= '0;
`endif
        end else begin
            state       <= stateNext;
            idx         <= idxNext;
            ptr         <= ptrNext;
            weL         <= weNext;
            grant       <= grantNext;
            done        <= doneNext;
            rdata       <= rdataNext;
            err         <= errNext;
            ram_address <= addrNext;
            ram_data_in <= dataNext;
            ram_read    <= readNext;
            ram_write   <= writeNext;
`ifdef RAM_ARB_TIMEOUT_EN
            cnt         <= cntNext;
`endif
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter (NREQ=3, AW=16, DW=8, TIMEOUT=4).
module tb_ram_port_arbiter;

    logic        clk;
    logic        rstN;
    logic [2:0]  req, we;
    logic [47:0] addr;
    logic [23:0] wdata;
    logic [2:0]  grant, done;
    logic [7:0]  rdata;
    logic        err;
    logic [15:0] ramAddress;
    logic [7:0]  ramDataIn;
    logic        ramRead, ramWrite;
    logic [7:0]  ramDataOut;
    logic        ramDoneRead, ramDoneWrite;

    int nVec = 0;
    int nBad = 0;

    ram_port_arbiter #(.NREQ(3), .AW(16), .DW(8), .TIMEOUT(4)) dut (
        .clk            (clk),
        .RST            (rstN),
        .req            (req),
        .we             (we),
        .addr           (addr),
        .wdata          (wdata),
        .grant          (grant),
        .done           (done),
        .rdata          (rdata),
        .err            (err),
        .ram_address    (ramAddress),
        .ram_data_in    (ramDataIn),
        .ram_read       (ramRead),
        .ram_write      (ramWrite),
        .ram_data_out   (ramDataOut),
        .ram_done_read  (ramDoneRead),
        .ram_done_write (ramDoneWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_rd"}, 32'(ramRead), 32'h0);
        chk({tag, "_wr"}, 32'(ramWrite), 32'h0);
        chk({tag, "_addr"}, 32'(ramAddress), 32'h0);
    endtask

    logic [2:0] expG;

    initial begin
        rstN = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
        ramDataOut = '0; ramDoneRead = 1'b0; ramDoneWrite = 1'b0;
        step(); step();
        checkIdle("rst");
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rstN = 1'b1;

        // 1: read from requester 0, DMA answers after 2 cycles
        req = 3'b001; we = 3'b000; addr[15:0] = 16'h0040;
        step();
        chk("rd_grant", 32'(grant), 32'h1);
        chk("rd_strobe", 32'(ramRead), 32'h1);
        chk("rd_wstrobe", 32'(ramWrite), 32'h0);
        chk("rd_addr", 32'(ramAddress), 32'h0040);
        step();
        chk("rd_wait_grant", 32'(grant), 32'h1);
        chk("rd_wait_done", 32'(done), 32'h0);
        ramDoneRead = 1'b1; ramDataOut = 8'hA5;
        step();
        chk("rd_done", 32'(done), 32'h1);
        chk("rd_done_grant", 32'(grant), 32'h1);
        chk("rd_rdata", 32'(rdata), 32'hA5);
        chk("rd_strobe_off", 32'(ramRead), 32'h0);
        chk("rd_err", 32'(err), 32'h0);
        ramDoneRead = 1'b0; req = '0;
        step();
        checkIdle("rd_idle");
        chk("rd_rdata_hold", 32'(rdata), 32'hA5);

        // 2: write from requester 1
        req = 3'b010; we = 3'b010; addr[31:16] = 16'h1234; wdata[15:8] = 8'h3C;
        step();
        chk("wr_grant", 32'(grant), 32'h2);
        chk("wr_strobe", 32'(ramWrite), 32'h1);
        chk("wr_rstrobe", 32'(ramRead), 32'h0);
        chk("wr_addr", 32'(ramAddress), 32'h1234);
        chk("wr_data", 32'(ramDataIn), 32'h3C);
        ramDoneWrite = 1'b1;
        step();
        chk("wr_done", 32'(done), 32'h2);
        chk("wr_rstrobe2", 32'(ramRead), 32'h0);
        chk("wr_strobe_off", 32'(ramWrite), 32'h0);
        ramDoneWrite = 1'b0; req = '0; we = '0;
        step();
        checkIdle("wr_idle");
        chk("wr_data_idle", 32'(ramDataIn), 32'h0);

        // 3: contention from ptr=0, all held, 1-cycle DMA
        rstN = 1'b0; step(); rstN = 1'b1;
        addr = {16'h0300, 16'h0200, 16'h0100};
        req = 3'b111; we = 3'b000;
        for (int t = 0; t < 4; t++) begin
            expG = 3'b001 << (t % 3);
            step();
            chk("rr_grant", 32'(grant), 32'(expG));
            chk("rr_addr", 32'(ramAddress), 32'((t % 3 + 1) * 256));
            ramDoneRead = 1'b1; ramDataOut = 8'(8'h10 + t);
            step();
            chk("rr_done", 32'(done), 32'(expG));
            chk("rr_rdata", 32'(rdata), 32'(8'h10 + t));
            ramDoneRead = 1'b0;
            if (t == 3) req = '0;
            step();
            chk("rr_done_1cyc", 32'(done), 32'h0);
            chk("rr_gap_grant", 32'(grant), 32'h0);
        end

        // 4: capture at grant; mismatched done ignored (ptr=1, search wraps to 0)
        req = 3'b001; we = 3'b000; addr[15:0] = 16'h0100;
        step();
        chk("cap_grant", 32'(grant), 32'h1);
        addr[15:0] = 16'hFFFF; we = 3'b001; ramDoneWrite = 1'b1;
        step();
        chk("cap_addr", 32'(ramAddress), 32'h0100);
        chk("cap_busy_done", 32'(done), 32'h0);
        chk("cap_busy_rd", 32'(ramRead), 32'h1);
        chk("cap_busy_wr", 32'(ramWrite), 32'h0);
        ramDoneWrite = 1'b0; ramDoneRead = 1'b1; ramDataOut = 8'h5A;
        step();
        chk("cap_done", 32'(done), 32'h1);
        chk("cap_rdata", 32'(rdata), 32'h5A);
        ramDoneRead = 1'b0; req = '0; we = '0;
        step();

        // 5: reset mid-transaction, then requester 2 first
        req = 3'b010; we = 3'b010;
        step();
        chk("rs_grant", 32'(grant), 32'h2);
        rstN = 1'b0;
        #1;
        checkIdle("rs_async");
        step();
        chk("rs_no_done", 32'(done), 32'h0);
        rstN = 1'b1; req = 3'b100; we = 3'b000; addr[47:32] = 16'h0ABC;
        step();
        chk("rs_grant2", 32'(grant), 32'h4);
        chk("rs_addr2", 32'(ramAddress), 32'h0ABC);
        ramDoneRead = 1'b1; ramDataOut = 8'h77;
        step();
        chk("rs_done2", 32'(done), 32'h4);
        chk("rs_rdata2", 32'(rdata), 32'h77);
        ramDoneRead = 1'b0; req = '0;
        step();

`ifdef RAM_ARB_TIMEOUT_EN
        // 6: DMA never answers; strobe for 4 BUSY cycles, then err with done
        req = 3'b001; we = 3'b000;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("to_strobe", 32'(ramRead), 32'h1);
            chk("to_err_low", 32'(err), 32'h0);
        end
        step();
        chk("to_strobe_off", 32'(ramRead), 32'h0);
        chk("to_err", 32'(err), 32'h1);
        chk("to_done", 32'(done), 32'h1);
        chk("to_rdata_kept", 32'(rdata), 32'h77);
        req = '0;
        step();
        chk("to_err_pulse", 32'(err), 32'h0);
        chk("to_done_pulse", 32'(done), 32'h0);
        req = 3'b010; we = 3'b000; addr[31:16] = 16'h2222;
        step();
        chk("to_next_grant", 32'(grant), 32'h2);
        ramDoneRead = 1'b1; ramDataOut = 8'hC3;
        step();
        chk("to_next_done", 32'(done), 32'h2);
        chk("to_next_rdata", 32'(rdata), 32'hC3);
        ramDoneRead = 1'b0; req = '0;
        step();
`else
        // Without the timeout a silent DMA leaves the arbiter waiting, err stays low
        req = 3'b001; we = 3'b000;
        repeat (8) step();
        chk("nto_still_busy", 32'(ramRead), 32'h1);
        chk("nto_no_done", 32'(done), 32'h0);
        chk("nto_err", 32'(err), 32'h0);
        ramDoneRead = 1'b1; ramDataOut = 8'hC3;
        step();
        chk("nto_done", 32'(done), 32'h1);
        ramDoneRead = 1'b0; req = '0;
        step();
`endif
        checkIdle("end");

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
